// File: rtl/calc_host_loader.sv
// calc_host_loader
// Host-side initiator for the calculator mailbox in data memory.
// When a start is accepted it latches the operands, writes words 0..2 with
// one-cycle strobes, waits WAIT_CYCLES cycles while the CPU program computes,
// then strobes a read of word 3 and captures the result.
// Optional build macro CALC_RESULT_STABLE_EN: reads the result twice and
// retries (up to 3 times) until two consecutive reads agree. It also adds the
// `mismatch` output.
module calc_host_loader #(
    parameter int unsigned WAIT_CYCLES = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] num_a,
    input  logic [31:0] num_b,
    input  logic [31:0] op_code,
    input  logic [31:0] result_output,
    output logic        mem_wd_NumberOne,
    output logic [31:0] numberOne,
    output logic        mem_wd_NumberTwo,
    output logic [31:0] numberTwo,
    output logic        mem_wd_Operation,
    output logic [31:0] operation,
    output logic        mem_rd_Result,
    output logic [31:0] result,
    output logic        busy,
    output logic        done
`ifdef CALC_RESULT_STABLE_EN
    ,
    output logic        mismatch
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_A,
        S_WR_B,
        S_WR_OP,
        S_WAIT,
`ifdef CALC_RESULT_STABLE_EN
        S_RD1,
        S_RD2,
`else
        S_RD,
`endif
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       number_one_q, number_one_d;
    logic [31:0]       number_two_q, number_two_d;
    logic [31:0]       operation_q, operation_d;
    logic [31:0]       result_q, result_d;
    logic              wr_a_q, wr_a_d;
    logic              wr_b_q, wr_b_d;
    logic              wr_op_q, wr_op_d;
    logic              rd_q, rd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef CALC_RESULT_STABLE_EN
    logic [31:0]       sample_q, sample_d;
    logic [1:0]        retry_q, retry_d;
    logic              mismatch_q, mismatch_d;
    logic              give_up;
`endif

    // State, counter, data and registered-output flops with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            number_one_q <= '0;
            number_two_q <= '0;
            operation_q  <= '0;
            result_q     <= '0;
            wr_a_q       <= 1'b0;
            wr_b_q       <= 1'b0;
            wr_op_q      <= 1'b0;
            rd_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef CALC_RESULT_STABLE_EN
            sample_q     <= '0;
            retry_q      <= '0;
            mismatch_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            number_one_q <= number_one_d;
            number_two_q <= number_two_d;
            operation_q  <= operation_d;
            result_q     <= result_d;
            wr_a_q       <= wr_a_d;
            wr_b_q       <= wr_b_d;
            wr_op_q      <= wr_op_d;
            rd_q         <= rd_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef CALC_RESULT_STABLE_EN
            sample_q     <= sample_d;
            retry_q      <= retry_d;
            mismatch_q   <= mismatch_d;
`endif
        end
    end

    // Next-state logic plus operand latch, wait counter and result capture.
    always_comb begin
        // NOTE: every variable gets a hold default first so no path through
        // the case statement can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        number_one_d = number_one_q;
        number_two_d = number_two_q;
        operation_d  = operation_q;
        result_d     = result_q;
`ifdef CALC_RESULT_STABLE_EN
        sample_d     = sample_q;
        retry_d      = retry_q;
        give_up      = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    number_one_d = num_a;
                    number_two_d = num_b;
                    operation_d  = op_code;
`ifdef CALC_RESULT_STABLE_EN
                    retry_d      = '0;
`endif
                    state_d      = S_WR_A;
                end
            end
            S_WR_A:  state_d = S_WR_B;
            S_WR_B:  state_d = S_WR_OP;
            S_WR_OP: begin
                cnt_d   = CNT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
`ifdef CALC_RESULT_STABLE_EN
                    state_d = S_RD1;
`else
                    state_d = S_RD;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef CALC_RESULT_STABLE_EN
            S_RD1: begin
                sample_d = result_output;
                state_d  = S_RD2;
            end
            S_RD2: begin
                if (result_output == sample_q) begin
                    result_d = sample_q;
                    state_d  = S_DONE;
                end else if (retry_q == 2'd3) begin
                    // Out of retries: keep the latest read and flag it.
                    result_d = result_output;
                    give_up  = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    retry_d  = retry_q + 2'd1;
                    cnt_d    = CNT_LOAD;
                    state_d  = S_WAIT;
                end
            end
`else
            S_RD: begin
                result_d = result_output;
                state_d  = S_DONE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state, so strobes come straight off flops.
    always_comb begin
        wr_a_d  = (state_d == S_WR_A);
        wr_b_d  = (state_d == S_WR_B);
        wr_op_d = (state_d == S_WR_OP);
`ifdef CALC_RESULT_STABLE_EN
        rd_d       = (state_d == S_RD1) || (state_d == S_RD2);
        mismatch_d = give_up;
`else
        rd_d    = (state_d == S_RD);
`endif
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    assign mem_wd_NumberOne = wr_a_q;
    assign mem_wd_NumberTwo = wr_b_q;
    assign mem_wd_Operation = wr_op_q;
    assign mem_rd_Result    = rd_q;
    assign numberOne        = number_one_q;
    assign numberTwo        = number_two_q;
    assign operation        = operation_q;
    assign result           = result_q;
    assign busy             = busy_q;
    assign done             = done_q;
`ifdef CALC_RESULT_STABLE_EN
    assign mismatch         = mismatch_q;
`endif

endmodule

// File: tb/tb_calc_host_loader.sv
// Testbench for calc_host_loader: random and directed starts, a mailbox
// memory with a CPU stand-in, and a scoreboard of expected runs.
module tb_calc_host_loader;

    localparam int W = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] num_a = '0;
    logic [31:0] num_b = '0;
    logic [31:0] op_code = '0;
    logic [31:0] result_output = '0;
    logic        mem_wd_NumberOne, mem_wd_NumberTwo, mem_wd_Operation, mem_rd_Result;
    logic [31:0] numberOne, numberTwo, operation, result;
    logic        busy, done;
`ifdef CALC_RESULT_STABLE_EN
    logic        mismatch;
`endif

    calc_host_loader #(.WAIT_CYCLES(W), .CNT_W(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .num_a            (num_a),
        .num_b            (num_b),
        .op_code          (op_code),
        .result_output    (result_output),
        .mem_wd_NumberOne (mem_wd_NumberOne),
        .numberOne        (numberOne),
        .mem_wd_NumberTwo (mem_wd_NumberTwo),
        .numberTwo        (numberTwo),
        .mem_wd_Operation (mem_wd_Operation),
        .operation        (operation),
        .mem_rd_Result    (mem_rd_Result),
        .result           (result),
        .busy             (busy),
        .done             (done)
`ifdef CALC_RESULT_STABLE_EN
        ,
        .mismatch         (mismatch)
`endif
    );

    always #5 clk = ~clk;

    // One accepted computation: edge at which start was taken, operands, answer.
    typedef struct {
        int          e;
        logic [31:0] a, b, op, res;
    } run_t;

    run_t        sb[$];
    int          edge_cnt = 0;
    int          next_accept = 0;
    int          rst_edge = 0;
    bit          rst_pend = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cpu_cnt = 0;
    logic [31:0] mem [4] = '{default: '0};
    logic [31:0] exp_n1 = '0, exp_n2 = '0, exp_op = '0, exp_res = '0;

    // What the CPU program computes from the mailbox words.
    function automatic logic [31:0] calc(input logic [31:0] a, b, op);
        case (op)
            32'd0:   return a + b;
            32'd1:   return a - b;
            32'd2:   return a & b;
            default: return a | b;
        endcase
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_cnt, act, exp);
        end
    endtask

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Drive inputs for the next edge and predict whether that edge accepts a start.
    task automatic step(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] op, input logic r);
        run_t t;
        @(posedge clk);
        #2;
        start = s; num_a = a; num_b = b; op_code = op; reset = r;
        if (r) begin
            rst_edge = edge_cnt + 1;
            rst_pend = 1'b1;
            next_accept = edge_cnt + 2;
        end else if (s && (edge_cnt + 1 >= next_accept)) begin
            t.e = edge_cnt + 1; t.a = a; t.b = b; t.op = op; t.res = calc(a, b, op);
            sb.push_back(t);
            next_accept = edge_cnt + 1 + W + 6;
        end
    endtask

    // Mailbox memory plus a CPU that publishes word 3 some time after word 2 lands.
    always @(negedge clk) begin
        if (mem_wd_NumberOne) mem[0] = numberOne;
        if (mem_wd_NumberTwo) mem[1] = numberTwo;
        if (mem_wd_Operation) begin
            mem[2] = operation;
            cpu_cnt = $urandom_range(W, 1);
        end else if (cpu_cnt > 0) begin
            cpu_cnt--;
            if (cpu_cnt == 0) begin
                mem[3] = calc(mem[0], mem[1], mem[2]);
                result_output = mem[3];
            end
        end
    end

    // Monitor: compare every cycle against the front run of the scoreboard.
    always @(negedge clk) begin
        logic [5:0] exp_ctrl;
        int         d;
        bit         do_pop;
        if (edge_cnt > 0) begin
            if (rst_pend && edge_cnt >= rst_edge) begin
                while (sb.size() > 0 && sb[0].e <= rst_edge) void'(sb.pop_front());
                exp_n1 = '0; exp_n2 = '0; exp_op = '0; exp_res = '0;
                rst_pend = 1'b0;
            end
            exp_ctrl = '0;
            do_pop = 1'b0;
            if (sb.size() > 0 && edge_cnt >= sb[0].e) begin
                d = edge_cnt - sb[0].e;
                exp_ctrl = {d == 0, d == 1, d == 2, d == W + 3, d == W + 4, d <= W + 4};
                if (d == 0) begin
                    exp_n1 = sb[0].a; exp_n2 = sb[0].b; exp_op = sb[0].op;
                end
                if (d == W + 4) begin
                    exp_res = sb[0].res;
                    do_pop = 1'b1;
                end
            end
            check("ctrl{wa,wb,wop,rd,done,busy}",
                  {mem_wd_NumberOne, mem_wd_NumberTwo, mem_wd_Operation, mem_rd_Result, done, busy},
                  exp_ctrl);
            check("buses", {numberOne, numberTwo, operation}, {exp_n1, exp_n2, exp_op});
            check("result", result, exp_res);
            check("strobe_exclusive",
                  ($countones({mem_wd_NumberOne, mem_wd_NumberTwo, mem_wd_Operation, mem_rd_Result}) <= 1),
                  1'b1);
            if (do_pop) void'(sb.pop_front());
        end
    end

    initial begin
        logic [31:0] op;
        // Reset, then the nominal run 18 + 7 with op 0.
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(1, 32'd18, 32'd7, 32'd0, 0);
        repeat (3) step(0, 32'd18, 32'd7, 32'd0, 0);
        // Start while busy must be ignored.
        step(1, 32'd5, 32'd9, 32'd1, 0);
        while (edge_cnt + 1 < next_accept) step(0, 0, 0, 0, 0);
        // Start held high: back-to-back runs.
        for (int i = 0; i < 2 * (W + 6) + 2; i++)
            step(1, $urandom, $urandom, $urandom_range(0, 3), 0);
        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            op = ($urandom_range(0, 4) == 0) ? $urandom : $urandom_range(0, 3);
            step($urandom_range(0, 3) == 0, $urandom, $urandom, op, 0);
        end
        // Reset in the middle of WAIT.
        while (edge_cnt + 1 < next_accept) step(0, 0, 0, 0, 0);
        step(1, $urandom, $urandom, 32'd1, 0);
        repeat (7) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        repeat (6) step(0, 0, 0, 0, 0);
        // One more run after the abort, then drain with a bound.
        step(1, 32'd100, 32'd58, 32'd1, 0);
        for (int i = 0; i < 200 && sb.size() > 0; i++) step(0, 0, 0, 0, 0);
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d runs outstanding, expected 0", sb.size());
        end
        repeat (3) step(0, 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
